// File: rtl/serial_incrementer_ctrl.sv
// rtl/serial_incrementer_ctrl.sv - bit-serial +1 engine over one half-adder cell, LSB first
// Optional build macro: SERIAL_INC_SAT_EN (saturate to all ones on carry-out).

module half_adder_2x4_decoder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    logic [3:0] dec;

    // One-hot decode of {a,b}; sum is the odd-parity minterms, carry the top one.
    always_comb begin
        dec = 4'b0000;
        case ({a, b})
            2'b00:   dec = 4'b0001;
            2'b01:   dec = 4'b0010;
            2'b10:   dec = 4'b0100;
            default: dec = 4'b1000;
        endcase
    end

    assign sum   = dec[1] | dec[2];
    assign carry = dec[3];
endmodule

module serial_incrementer_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             cell_sum;
    logic             cell_carry;
    logic             last_bit;
    logic [WIDTH-1:0] sr_shifted;

    half_adder_2x4_decoder u_cell (
        .a     (sr[0]),
        .b     (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign last_bit   = (count == CNT_W'(WIDTH - 1));
    assign sr_shifted = {cell_sum, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Datapath: the carry flop is preloaded with 1 so the first bit adds the +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr    <= operand;
                        carry <= 1'b1;
                        count <= '0;
                    end
                end
                ST_RUN: begin
                    sr    <= sr_shifted;
                    carry <= cell_carry;
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers load on the final bit-cycle so they are valid during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (state == ST_RUN && last_bit) begin
`ifdef SERIAL_INC_SAT_EN
            result   <= cell_carry ? {WIDTH{1'b1}} : sr_shifted;
`else
            result   <= sr_shifted;
`endif
            overflow <= cell_carry;
        end
    end
endmodule

// File: tb/tb_serial_incrementer_ctrl.sv
// tb/tb_serial_incrementer_ctrl.sv - directed self-checking bench for serial_incrementer_ctrl

module tb_serial_incrementer_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] operand;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    int total;
    int bad;

    serial_incrementer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start pulse and waits for done; returns observed values.
    task automatic do_op(input logic [WIDTH-1:0] op, output logic [WIDTH-1:0] res,
                         output logic ovf, output int nbusy, output logic got_done);
        @(negedge clk);
        start   = 1'b1;
        operand = op;
        @(negedge clk);
        start    = 1'b0;
        nbusy    = 0;
        got_done = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        res = result;
        ovf = overflow;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        operand = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%h ovf=%b, required 0 0 00 0",
                         i, busy, done, result, overflow);
            end
        end
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] ops [4];
        logic [WIDTH-1:0] exp_res [4];
        logic             exp_ovf [4];
        logic [WIDTH-1:0] r;
        logic             o;
        logic             gd;
        int               nb;
        ops[0] = 8'h00; exp_res[0] = 8'h01; exp_ovf[0] = 1'b0;
        ops[1] = 8'h7F; exp_res[1] = 8'h80; exp_ovf[1] = 1'b0;
        ops[2] = 8'hA5; exp_res[2] = 8'hA6; exp_ovf[2] = 1'b0;
`ifdef SERIAL_INC_SAT_EN
        ops[3] = 8'hFF; exp_res[3] = 8'hFF; exp_ovf[3] = 1'b1;
`else
        ops[3] = 8'hFF; exp_res[3] = 8'h00; exp_ovf[3] = 1'b1;
`endif
        for (int v = 0; v < 4; v++) begin
            do_op(ops[v], r, o, nb, gd);
            total++;
            if (gd !== 1'b1) begin
                bad++;
                $display("FAIL vec%0d_done_timeout: done=%b, required 1", v, gd);
            end
            total++;
            if (nb != WIDTH) begin
                bad++;
                $display("FAIL vec%0d_busy_cycles: got %0d, required %0d", v, nb, WIDTH);
            end
            total++;
            if (r !== exp_res[v] || o !== exp_ovf[v]) begin
                bad++;
                $display("FAIL vec%0d_result op=%h: got %h ovf=%b, required %h ovf=%b",
                         v, ops[v], r, o, exp_res[v], exp_ovf[v]);
            end
            repeat (3) @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res[v] || overflow !== exp_ovf[v]) begin
                bad++;
                $display("FAIL vec%0d_hold: done=%b busy=%b result=%h ovf=%b, required 0 0 %h %b",
                         v, done, busy, result, overflow, exp_res[v], exp_ovf[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic gd;
        @(negedge clk);
        start   = 1'b1;
        operand = 8'h10;
        @(negedge clk);
        repeat (3) @(negedge clk);
        operand = 8'h20;
        gd = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (gd !== 1'b1 || result !== 8'h11 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL held_start_first: done=%b result=%h ovf=%b, required 1 11 0", gd, result, overflow);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL held_start_idle_gap: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL held_start_reaccept: busy=%b, required 1", busy);
        end
        gd = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (gd !== 1'b1 || result !== 8'h21) begin
            bad++;
            $display("FAIL held_start_second: done=%b result=%h, required 1 21", gd, result);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] r;
        logic             o;
        logic             gd;
        int               nb;
        int               seen_done;
        @(negedge clk);
        start   = 1'b1;
        operand = 8'h33;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: busy=%b done=%b result=%h ovf=%b, required 0 0 00 0",
                     busy, done, result, overflow);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        total++;
        if (seen_done != 0 || result !== 8'h00) begin
            bad++;
            $display("FAIL midrun_no_done: activity cycles=%0d result=%h, required 0 00", seen_done, result);
        end
        do_op(8'hA5, r, o, nb, gd);
        total++;
        if (gd !== 1'b1 || nb != WIDTH || r !== 8'hA6 || o !== 1'b0) begin
            bad++;
            $display("FAIL midrun_recover: done=%b busy_cycles=%0d result=%h ovf=%b, required 1 %0d a6 0",
                     gd, nb, r, o, WIDTH);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
